seven_seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 17 +
 rtl/seven_seg_scan_ctrl_bcd_to_seg.sv | 11 +
 rtl/seven_seg_scan_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_scan_ctrl_pkg: shared segment codes and scan FSM encoding
package seven_seg_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low pin codes {a,b,c,d,e,f,g}; non-BCD nibbles are blank.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    typedef enum logic {
        S_DRIVE = 1'b0,
        S_GAP   = 1'b1
    } state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low 7-segment decode, blank above 9
module bcd_to_seg
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed N-digit 7-segment scanner with tear-free frame loading
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DRIVE_CYC  = 50000,
    parameter int GAP_CYC    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int               IDX_W      = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic                    phase_end, frame_end;
    logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp, lz_zero;
    logic                    pend_full, lz_blank;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    // Dwell timing, digit advance and frame-boundary detection for the scan FSM
    always_comb begin
        phase_end  = cnt == (state == S_DRIVE ? DRIVE_LAST : GAP_LAST);
        frame_end  = phase_end && idx == IDX_LAST && (state == S_GAP || GAP_CYC == 0);
        state_next = state;
        cnt_next   = phase_end ? '0 : cnt + 1'b1;
        idx_next   = idx;
        if (phase_end) begin
            state_next = (state == S_DRIVE && GAP_CYC > 0) ? S_GAP : S_DRIVE;
            idx_next   = state_next == S_DRIVE ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
        end
    end

    // Scan state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_DRIVE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Frame capture into pending; commit to display only at a frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (load_valid && !pend_full) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
                pend_full <= 1'b1;
            end
            if (frame_end && pend_full) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end
        end
    end

    assign load_ready = !pend_full;

    // Digit i is a leading zero when it and every more significant nibble are zero
    always_comb begin
        lz_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            lz_zero[i] = (disp_data >> (4 * i)) == '0;
    end

    assign nibble   = disp_data[4*idx +: 4];
    assign lz_blank = blank_lz && idx != '0 && lz_zero[idx];

    bcd_to_seg u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    // Registered pin drive: current digit during DRIVE, everything off during GAP
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            seg        <= (state == S_DRIVE && !lz_blank) ? dec_seg : SEG_BLANK;
            dp         <= !(state == S_DRIVE && disp_dp[idx]);
            an         <= state == S_DRIVE ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end

endmodule
